// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array and its job sequencer.
package systolic_array_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned SA_FLUSH_BEATS = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        SA_IDLE,
        SA_CLEAR,
        SA_LOAD,
        SA_FLUSH,
        SA_SETTLE,
        SA_DRAIN
    } sa_ctrl_state_t;

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Command, operand, array and result signals of the systolic array sequencer.
interface systolic_array_ctrl_if #(
    parameter int unsigned N = 4
);
    import systolic_array_pkg::*;

    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              op_valid;
    logic              op_ready;
    word_t [N-1:0]     op_x;
    word_t [N-1:0]     op_w;
    logic              sa_clear;
    logic              sa_start;
    word_t [N-1:0]     sa_x;
    word_t [N-1:0]     sa_w;
    logic              sa_stall;
    logic [ROW_W-1:0]  sa_row_sel;
    word_t [N-1:0]     sa_y;
    logic              res_valid;
    logic              res_ready;
    word_t [N-1:0]     res_data;
    logic              res_last;
    logic              busy;

    // Sequencer side
    modport slave (
        input  cmd_valid, op_valid, op_x, op_w, sa_stall, sa_y, res_ready,
        output cmd_ready, op_ready, sa_clear, sa_start, sa_x, sa_w,
               sa_row_sel, res_valid, res_data, res_last, busy
    );

    // Environment side: operand source, array and result sink
    modport master (
        output cmd_valid, op_valid, op_x, op_w, sa_stall, sa_y, res_ready,
        input  cmd_ready, op_ready, sa_clear, sa_start, sa_x, sa_w,
               sa_row_sel, res_valid, res_data, res_last, busy
    );

endinterface

// File: rtl/systolic_array_ctrl_counter.sv
// Up-counter with clear, enable and a terminal-value flag.
module sa_beat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             hit_c
);

    // Clear wins over enable so a terminal beat can restart the count
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign hit_c = (count == term);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: clears the array, streams 2N operand beats plus flush beats,
// then drains the N psum rows as a valid/ready result stream.
module systolic_array_ctrl
    import systolic_array_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned FLUSH = SA_FLUSH_BEATS
) (
    input logic                  clk,
    input logic                  rst,
    systolic_array_ctrl_if.slave bus
);

    localparam int unsigned BEAT_W = $clog2(2 * N + 1);
    localparam int unsigned ROW_W  = (N > 1) ? $clog2(N) : 1;

    sa_ctrl_state_t    state_q;
    sa_ctrl_state_t    state_d;

    logic              beat_clr;
    logic              beat_en;
    logic              beat_hit;
    logic [BEAT_W-1:0] beat_term;
    logic [BEAT_W-1:0] unused_beat_cnt;

    logic              row_clr;
    logic              row_en;
    logic              row_hit;
    logic [ROW_W-1:0]  row_cnt;

    // One counter serves both operand beats and flush beats
    assign beat_term = (state_q == SA_LOAD) ? BEAT_W'(2 * N - 1) : BEAT_W'(FLUSH - 1);

    sa_beat_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (beat_clr),
        .en    (beat_en),
        .term  (beat_term),
        .count (unused_beat_cnt),
        .hit_c (beat_hit)
    );

    sa_beat_counter #(.WIDTH(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (row_clr),
        .en    (row_en),
        .term  (ROW_W'(N - 1)),
        .count (row_cnt),
        .hit_c (row_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SA_IDLE;
            bus.busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus.busy <= (state_d != SA_IDLE);
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_clr       = 1'b0;
        beat_en        = 1'b0;
        row_clr        = 1'b0;
        row_en         = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.op_ready   = 1'b0;
        bus.sa_clear   = 1'b0;
        bus.sa_start   = 1'b0;
        bus.sa_x       = '0;
        bus.sa_w       = '0;
        bus.sa_row_sel = '0;
        bus.res_valid  = 1'b0;
        bus.res_data   = '0;
        bus.res_last   = 1'b0;

        unique case (state_q)
            SA_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    beat_clr = 1'b1;
                    row_clr  = 1'b1;
                    state_d  = SA_CLEAR;
                end
            end

            SA_CLEAR: begin
                bus.sa_clear = 1'b1;
                state_d      = SA_LOAD;
            end

            // A stalled beat stays upstream; a bubble presents zeros
            SA_LOAD: begin
                if (bus.op_valid) begin
                    bus.sa_x = bus.op_x;
                    bus.sa_w = bus.op_w;
                end
                if (bus.op_valid && !bus.sa_stall) begin
                    bus.op_ready = 1'b1;
                    bus.sa_start = 1'b1;
                    beat_en      = 1'b1;
                    if (beat_hit) begin
                        beat_clr = 1'b1;
                        state_d  = SA_FLUSH;
                    end
                end
            end

            SA_FLUSH: begin
                if (!bus.sa_stall) begin
                    bus.sa_start = 1'b1;
                    beat_en      = 1'b1;
                    if (beat_hit) begin
                        state_d = SA_SETTLE;
                    end
                end
            end

            SA_SETTLE: begin
                if (!bus.sa_stall) begin
                    state_d = SA_DRAIN;
                end
            end

            SA_DRAIN: begin
                bus.sa_row_sel = row_cnt;
                bus.res_data   = bus.sa_y;
                bus.res_valid  = 1'b1;
                bus.res_last   = row_hit;
                if (bus.res_ready) begin
                    row_en = 1'b1;
                    if (row_hit) begin
                        state_d = SA_IDLE;
                    end
                end
            end

            default: begin
                state_d = SA_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural accumulate-only array stub.
module tb_systolic_array_ctrl;
    import systolic_array_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned ROW_W = $clog2(N);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_array_ctrl_if #(.N(N)) bus ();

    systolic_array_ctrl #(.N(N), .FLUSH(SA_FLUSH_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc, nop, nclr, nst, wacc;

    logic [63:0]   exp_rows [N];
    word_t [N-1:0] beat_x [2*N];
    word_t [N-1:0] beat_w [2*N];
    word_t         psum [N][N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Array stub: clear, then accumulate outer products on each advance
    always_ff @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (bus.sa_clear) begin
                    psum[r][c] <= '0;
                end else if (bus.sa_start && !bus.sa_stall) begin
                    psum[r][c] <= psum[r][c] + word_t'(bus.sa_x[r] * bus.sa_w[c]);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) begin
            bus.sa_y[c] = psum[bus.sa_row_sel][c];
        end
    end

    task automatic run_job(input int ld_stall, input int fl_stall, input bit bubbles,
                           input int bp_len, input bit keep_cmd,
                           output int n_cyc, output int n_op, output int n_clr,
                           output int n_start, output int wait_acc);
        int op_idx = 0;
        int rows = 0;
        int guard = 0;
        bit accepted = 1'b0;
        bit prev_bp = 1'b0;
        bit stall_now;
        bit bubble_now;
        bit bp_now;
        logic [63:0]      held_data = '0;
        logic [ROW_W-1:0] held_sel = '0;
        n_cyc = 0; n_op = 0; n_clr = 0; n_start = 0; wait_acc = 0;
        while (rows < int'(N) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            stall_now = 1'b0;
            if (op_idx == 2 && ld_stall > 0) begin
                stall_now = 1'b1;
                ld_stall--;
            end else if (op_idx == int'(2 * N) && fl_stall > 0) begin
                stall_now = 1'b1;
                fl_stall--;
            end
            bubble_now    = bubbles && accepted && (n_cyc % 2 == 1);
            bus.cmd_valid = accepted ? keep_cmd : 1'b1;
            bus.sa_stall  = stall_now;
            bus.op_valid  = (op_idx < int'(2 * N)) && !bubble_now;
            bus.op_x      = bus.op_valid ? beat_x[op_idx] : '0;
            bus.op_w      = bus.op_valid ? beat_w[op_idx] : '0;
            #1;
            bp_now = bus.res_valid && rows == 1 && bp_len > 0;
            if (bp_now) bp_len--;
            bus.res_ready = !bp_now;
            #1;
            if (prev_bp) begin
                chk("bp_data", bus.res_data, held_data);
                chk("bp_sel", 64'(bus.sa_row_sel), 64'(held_sel));
            end
            prev_bp = bp_now;
            if (bp_now) begin
                held_data = bus.res_data;
                held_sel  = bus.sa_row_sel;
                chk("bp_row1", 64'(bus.sa_row_sel), 64'(1));
            end
            if (stall_now) begin
                chk("stall_op_ready", 64'(bus.op_ready), 64'(0));
                chk("stall_sa_start", 64'(bus.sa_start), 64'(0));
            end
            if (!bus.op_valid) begin
                chk("zero_sa_x", bus.sa_x, 64'(0));
                chk("zero_sa_w", bus.sa_w, 64'(0));
                if (op_idx < int'(2 * N)) chk("bubble_start", 64'(bus.sa_start), 64'(0));
            end
            if (accepted) chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
            if (bus.op_ready) begin
                n_op++;
                op_idx++;
            end
            if (bus.sa_clear) n_clr++;
            if (bus.sa_start) n_start++;
            if (bus.res_valid && bus.res_ready) begin
                chk("row_data", bus.res_data, exp_rows[rows]);
                chk("row_sel", 64'(bus.sa_row_sel), 64'(rows));
                chk("row_last", 64'(bus.res_last), 64'(rows == int'(N) - 1));
                rows++;
            end
            if (!accepted && bus.cmd_valid && bus.cmd_ready) accepted = 1'b1;
            else if (!accepted) wait_acc++;
            if (accepted) n_cyc++;
        end
        if (rows < int'(N)) chk("job_timeout", 64'(rows), 64'(N));
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.op_valid  = 1'b0;
        bus.sa_stall  = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    endtask

    task automatic job_counts(input string tag, input int e_cyc);
        chk({tag, "_cycles"}, 64'(cyc), 64'(e_cyc));
        chk({tag, "_op_ready"}, 64'(nop), 64'(2 * N));
        chk({tag, "_sa_clear"}, 64'(nclr), 64'(1));
        chk({tag, "_sa_start"}, 64'(nst), 64'(2 * N + SA_FLUSH_BEATS));
        chk({tag, "_accept_wait"}, 64'(wacc), 64'(0));
    endtask

    initial begin
        // x beats: identity repeated twice; w beat b, col c = 4b+c+1
        for (int b = 0; b < int'(2 * N); b++) begin
            for (int c = 0; c < int'(N); c++) begin
                beat_x[b][c] = (c == b % int'(N)) ? word_t'(1) : word_t'(0);
                beat_w[b][c] = word_t'(4 * b + c + 1);
            end
        end
        // psum[r][c] = w[r][c] + w[r+4][c] = 8r + 2c + 18
        exp_rows[0] = 64'h0018_0016_0014_0012;
        exp_rows[1] = 64'h0020_001E_001C_001A;
        exp_rows[2] = 64'h0028_0026_0024_0022;
        exp_rows[3] = 64'h0030_002E_002C_002A;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_x      = '0;
        bus.op_w      = '0;
        bus.sa_stall  = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_op_ready", 64'(bus.op_ready), 64'(0));
        chk("rst_sa_clear", 64'(bus.sa_clear), 64'(0));
        chk("rst_sa_start", 64'(bus.sa_start), 64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_res_last", 64'(bus.res_last), 64'(0));
        chk("rst_sa_x", bus.sa_x, 64'(0));
        chk("rst_res_data", bus.res_data, 64'(0));
        chk("rst_row_sel", 64'(bus.sa_row_sel), 64'(0));
        rst = 1'b0;

        run_job(0, 0, 1'b0, 0, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("ident", 17);
        idle_check("ident_end");

        run_job(3, 2, 1'b0, 0, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("stall", 22);
        idle_check("stall_end");

        run_job(0, 0, 1'b1, 0, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("bubble", 24);
        idle_check("bubble_end");

        run_job(0, 0, 1'b0, 4, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("bp", 21);
        idle_check("bp_end");

        run_job(0, 0, 1'b0, 0, 1'b1, cyc, nop, nclr, nst, wacc);
        job_counts("b2b_first", 17);
        run_job(0, 0, 1'b0, 0, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("b2b_second", 17);
        idle_check("b2b_end");

        // Reset in the middle of LOAD drops the job
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op_x      = beat_x[0];
        bus.op_w      = beat_w[0];
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
        #1;
        chk("pre_rst_busy", 64'(bus.busy), 64'(1));
        chk("pre_rst_op_ready", 64'(bus.op_ready), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_op_ready", 64'(bus.op_ready), 64'(0));
        chk("midrst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("midrst_sa_start", 64'(bus.sa_start), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.op_valid = 1'b0;

        run_job(0, 0, 1'b0, 0, 1'b0, cyc, nop, nclr, nst, wacc);
        job_counts("post_rst", 17);
        idle_check("post_rst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
